// File: rtl/r2sdf_commutator.sv
// R2SDF commutator for one radix-2 streaming FFT stage: buffers the first half-block,
// feeds the butterfly during the second half and recirculates its lower output.
module r2sdf_commutator #(
    parameter int bit_width = 16,
    parameter int DEPTH     = 4,
    parameter int TW_SHIFT  = 0,
    parameter int TW_W      = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [bit_width-1:0] in_re,
    input  logic [bit_width-1:0] in_im,
    output logic [bit_width-1:0] bf_re_i1,
    output logic [bit_width-1:0] bf_im_i1,
    output logic [bit_width-1:0] bf_re_i2,
    output logic [bit_width-1:0] bf_im_i2,
    output logic                 bf_en,
    output logic [TW_W-1:0]      tw_addr,
    input  logic [bit_width-1:0] bf_re_o1,
    input  logic [bit_width-1:0] bf_im_o1,
    input  logic [bit_width-1:0] bf_re_o2,
    input  logic [bit_width-1:0] bf_im_o2,
    output logic                 out_valid,
    output logic [bit_width-1:0] out_re,
    output logic [bit_width-1:0] out_im,
    output logic                 out_first
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int DW = 2 * bit_width;

    logic [CW-1:0]   cnt;
    logic            primed;
    logic            phase_b;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   dl [DEPTH];
    logic [DW-1:0]   head;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   candidate;
    logic [TW_W-1:0] tw_idx;

    assign phase_b = cnt[CW-1];
    assign idx     = cnt[IW-1:0];
    assign head    = dl[idx];

    assign bf_re_i1 = head[DW-1:bit_width];
    assign bf_im_i1 = head[bit_width-1:0];
    assign bf_re_i2 = in_re;
    assign bf_im_i2 = in_im;
    assign bf_en    = in_valid & phase_b;

    // Truncating before the shift equals truncating after it, since a left shift only drops high bits.
    assign tw_idx  = TW_W'(idx);
    assign tw_addr = phase_b ? (tw_idx << TW_SHIFT) : '0;

    always_comb begin
        wr_data   = {in_re, in_im};
        candidate = head;
        if (phase_b) begin
            wr_data   = {bf_re_o2, bf_im_o2};
            candidate = {bf_re_o1, bf_im_o1};
        end
    end

    // Delay line is never cleared; it only matters once a full block has been primed.
    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            dl[idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else if (in_valid) begin
            cnt       <= cnt + CW'(1);
            if (cnt == CW'(2 * DEPTH - 1)) begin
                primed <= 1'b1;
            end
            out_valid <= phase_b | primed;
            out_first <= phase_b && (idx == '0);
            out_re    <= candidate[DW-1:bit_width];
            out_im    <= candidate[bit_width-1:0];
        end else begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
        end
    end

endmodule
